// File: rtl/playbus_pkg.sv
// PlayBus shared definitions: controller states, function codes and the
// source/sink decode every controller file uses.
package playbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_WRITE    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_WAIT_REL = 3'd4,
    ST_NEXT     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    F_ROM_BUS = 3'd0,
    F_RAM_BUS = 3'd1,
    F_SW_BUS  = 3'd2,
    F_SW_RAM  = 3'd3,
    F_ROM_RAM = 3'd4,
    F_SW_LED  = 3'd5,
    F_RAM_LED = 3'd6,
    F_ROM_LED = 3'd7
  } func_t;

  typedef enum logic [1:0] {
    SRC_ROM = 2'd0,
    SRC_RAM = 2'd1,
    SRC_SW  = 2'd2
  } src_t;

  localparam logic [2:0] FUNC_FIRST_DYN = 3'd3;

  function automatic logic func_is_dynamic(input logic [2:0] f);
    return f >= FUNC_FIRST_DYN;
  endfunction

  function automatic src_t func_src(input func_t f);
    case (f)
      F_ROM_BUS, F_ROM_RAM, F_ROM_LED: return SRC_ROM;
      F_RAM_BUS, F_RAM_LED:            return SRC_RAM;
      default:                         return SRC_SW;
    endcase
  endfunction

  function automatic logic func_sink_ram(input func_t f);
    return (f == F_SW_RAM) || (f == F_ROM_RAM);
  endfunction

  function automatic logic func_sink_led(input func_t f);
    return f >= F_SW_LED;
  endfunction

endpackage

// File: rtl/playbus_if.sv
// PlayBus panel/memory signal bundle; master = panel side, slave = controller.
interface playbus_if #(
  parameter int AW = 4
);
  logic          GO;
  logic [2:0]    FUNC;
  logic [AW-1:0] ADD;
  logic          BLK;
  logic          n_ROMO;
  logic          n_RAMO;
  logic          n_SWBEN;
  logic          n_RAMW;
  logic          LEDLTCH;
  logic [AW-1:0] ADDR_OUT;
  logic          ADDR_SEL;
  logic          BUSY;
  logic [2:0]    St;

  modport master (
    output GO, FUNC, ADD, BLK,
    input  n_ROMO, n_RAMO, n_SWBEN, n_RAMW, LEDLTCH, ADDR_OUT, ADDR_SEL, BUSY, St
  );

  modport slave (
    input  GO, FUNC, ADD, BLK,
    output n_ROMO, n_RAMO, n_SWBEN, n_RAMW, LEDLTCH, ADDR_OUT, ADDR_SEL, BUSY, St
  );
endinterface

// File: rtl/playbus_strobe_timer.sv
// Write-strobe length counter: load at SETUP, done once WR_CYCLES clocks of
// WRITE have elapsed.
module playbus_strobe_timer #(
  parameter int WR_CYCLES = 1
) (
  input  logic CK2HZ,
  input  logic n_CLR,
  input  logic i_load,
  output logic o_done
);

  localparam int            CW       = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(WR_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CK2HZ or negedge n_CLR) begin
    if (!n_CLR) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/playbus_ctrl.sv
// PlayBus controller: 8-function decode, GO-latched transfers, registered write
// strobes. Optional block copy over ADD..all-ones with macro PLAYBUS_BLOCK_COPY_EN.
module playbus_ctrl
  import playbus_pkg::*;
#(
  parameter int AW        = 4,
  parameter int WR_CYCLES = 1
) (
  input logic      CK2HZ,
  input logic      n_CLR,
  playbus_if.slave bus
);

  state_t r_state;
  state_t w_next;
  func_t  r_func_q;
  func_t  w_func_live;
  logic   r_ramw;
  logic   r_ledltch;
  logic   r_busy;
  logic   w_start;
  logic   w_tmr_load;
  logic   w_tmr_done;
  logic   w_more_words;
  logic   w_src_en;
  src_t   w_src;

  assign w_func_live = func_t'(bus.FUNC);
  assign w_start     = bus.GO && func_is_dynamic(bus.FUNC);
  assign w_tmr_load  = (r_state == ST_SETUP);

  playbus_strobe_timer #(
    .WR_CYCLES(WR_CYCLES)
  ) u_strobe_timer (
    .CK2HZ (CK2HZ),
    .n_CLR (n_CLR),
    .i_load(w_tmr_load),
    .o_done(w_tmr_done)
  );

`ifdef PLAYBUS_BLOCK_COPY_EN
  logic          r_blk_q;
  logic          r_addr_sel;
  logic [AW-1:0] r_addr_cnt;
  logic          w_blk_nxt;

  assign w_blk_nxt    = (r_state == ST_IDLE) ? bus.BLK : r_blk_q;
  assign w_more_words = r_blk_q && (r_addr_cnt != '1);

  // Address only moves on entry to NEXT, when every source is off.
  always_ff @(posedge CK2HZ or negedge n_CLR) begin
    if (!n_CLR) begin
      r_blk_q    <= 1'b0;
      r_addr_cnt <= '0;
      r_addr_sel <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && w_start) begin
        r_blk_q    <= bus.BLK;
        r_addr_cnt <= bus.ADD;
      end else if (w_next == ST_NEXT) begin
        r_addr_cnt <= r_addr_cnt + 1'b1;
      end
      r_addr_sel <= w_blk_nxt &&
                    (w_next inside {ST_SETUP, ST_WRITE, ST_HOLD, ST_NEXT});
    end
  end

  assign bus.ADDR_SEL = r_addr_sel;
  assign bus.ADDR_OUT = r_addr_sel ? r_addr_cnt : bus.ADD;
`else
  assign w_more_words = 1'b0;
  assign bus.ADDR_SEL = 1'b0;
  assign bus.ADDR_OUT = bus.ADD;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_start) w_next = ST_SETUP;
      ST_SETUP:    w_next = ST_WRITE;
      ST_WRITE:    if (w_tmr_done) w_next = ST_HOLD;
      ST_HOLD:     w_next = w_more_words ? ST_NEXT : ST_WAIT_REL;
      ST_NEXT:     w_next = ST_SETUP;
      ST_WAIT_REL: if (!bus.GO) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Strobes/BUSY are registered from the next state so pins only move on edges.
  always_ff @(posedge CK2HZ or negedge n_CLR) begin
    if (!n_CLR) begin
      r_state   <= ST_IDLE;
      r_func_q  <= F_ROM_BUS;
      r_ramw    <= 1'b0;
      r_ledltch <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next;
      if ((r_state == ST_IDLE) && w_start) r_func_q <= w_func_live;
      r_ramw    <= (w_next == ST_WRITE) && func_sink_ram(r_func_q);
      r_ledltch <= (w_next == ST_WRITE) && func_sink_led(r_func_q);
      r_busy    <= (w_next != ST_IDLE);
    end
  end

  always_comb begin
    w_src_en = 1'b0;
    w_src    = SRC_ROM;
    case (r_state)
      ST_IDLE: begin
        w_src_en = !func_is_dynamic(bus.FUNC);
        w_src    = func_src(w_func_live);
      end
      ST_NEXT: w_src_en = 1'b0;
      default: begin
        w_src_en = 1'b1;
        w_src    = func_src(r_func_q);
      end
    endcase
  end

  assign bus.n_ROMO  = !(w_src_en && (w_src == SRC_ROM));
  assign bus.n_RAMO  = !(w_src_en && (w_src == SRC_RAM));
  assign bus.n_SWBEN = !(w_src_en && (w_src == SRC_SW));
  assign bus.n_RAMW  = ~r_ramw;
  assign bus.LEDLTCH = r_ledltch;
  assign bus.BUSY    = r_busy;
  assign bus.St      = r_state;

endmodule

// File: tb/tb_playbus_ctrl.sv
// Bench for playbus_ctrl: two instances (WR_CYCLES=1 and 3) on shared panel
// inputs; table vectors, directed sequences and a randomized run vs a schedule model.
module tb_playbus_ctrl;

`ifdef PLAYBUS_BLOCK_COPY_EN
  localparam bit BLK_EN = 1'b1;
`else
  localparam bit BLK_EN = 1'b0;
`endif
  localparam int AMAX = 15;
  localparam int SRC_OF [8] = '{0, 1, 2, 2, 0, 2, 1, 0};

  logic       ck = 1'b0;
  logic       nclr;
  logic       go;
  logic [2:0] func;
  logic [3:0] add;
  logic       blk;

  int n_chk  = 0;
  int n_fail = 0;

  playbus_if #(.AW(4)) b1 ();
  playbus_if #(.AW(4)) b3 ();

  assign b1.GO = go;  assign b1.FUNC = func;  assign b1.ADD = add;  assign b1.BLK = blk;
  assign b3.GO = go;  assign b3.FUNC = func;  assign b3.ADD = add;  assign b3.BLK = blk;

  playbus_ctrl #(.AW(4), .WR_CYCLES(1)) u1 (.CK2HZ(ck), .n_CLR(nclr), .bus(b1));
  playbus_ctrl #(.AW(4), .WR_CYCLES(3)) u3 (.CK2HZ(ck), .n_CLR(nclr), .bus(b3));

  always #5 ck = ~ck;

  logic [13:0] obs1, obs3;
  assign obs1 = {b1.St, b1.BUSY, b1.n_RAMW, b1.LEDLTCH, b1.n_ROMO, b1.n_RAMO,
                 b1.n_SWBEN, b1.ADDR_SEL, b1.ADDR_OUT};
  assign obs3 = {b3.St, b3.BUSY, b3.n_RAMW, b3.LEDLTCH, b3.n_ROMO, b3.n_RAMO,
                 b3.n_SWBEN, b3.ADDR_SEL, b3.ADDR_OUT};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge ck);
  endtask

  // Reference: one queue entry per clock of a run, entry = st*16 + address.
  int m_st [2];
  int m_fq [2];
  bit m_bq [2];
  int m_ad [2];
  int mq   [2][$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_fq[i] = 0; m_bq[i] = 1'b0; m_ad[i] = 0;
      mq[i].delete();
    end
  endtask

  task automatic model_pop(input int i);
    int e;
    e = mq[i].pop_front();
    m_st[i] = e / 16;
    m_ad[i] = e % 16;
  endtask

  task automatic model_step(input int i, input int wr);
    int last;
    if (m_st[i] == 0) begin
      if (go && func >= 3) begin
        m_fq[i] = int'(func);
        m_bq[i] = BLK_EN && blk;
        last = m_bq[i] ? AMAX : int'(add);
        for (int a = int'(add); a <= last; a++) begin
          if (a != int'(add)) mq[i].push_back(5 * 16 + a);
          mq[i].push_back(1 * 16 + a);
          for (int k = 0; k < wr; k++) mq[i].push_back(2 * 16 + a);
          mq[i].push_back(3 * 16 + a);
        end
        model_pop(i);
      end
    end else if (mq[i].size() > 0) begin
      model_pop(i);
    end else if (m_st[i] == 4) begin
      if (!go) m_st[i] = 0;
    end else begin
      m_st[i] = 4;
    end
  endtask

  function automatic logic [13:0] model_out(input int i);
    int       st, src;
    bit       en, sel, ramw, led;
    logic [2:0] s3;
    logic [3:0] ao;
    st   = m_st[i];
    s3   = st[2:0];
    en   = (st == 0) ? (func <= 3'd2) : (st != 5);
    src  = (st == 0) ? SRC_OF[func] : SRC_OF[m_fq[i]];
    sel  = m_bq[i] && (st == 1 || st == 2 || st == 3 || st == 5);
    ao   = sel ? 4'(m_ad[i]) : add;
    ramw = (st == 2) && (m_fq[i] == 3 || m_fq[i] == 4);
    led  = (st == 2) && (m_fq[i] >= 5);
    return {s3, st != 0, !ramw, led, !(en && src == 0), !(en && src == 1),
            !(en && src == 2), sel, ao};
  endfunction

  typedef struct {
    logic [2:0] func;
    logic       go;
    logic [2:0] exp_n;   // {n_ROMO, n_RAMO, n_SWBEN}
  } vec_t;
  vec_t tbl [11];

  int e1_st  [5] = '{1, 2, 3, 4, 0};
  int e1_led [5] = '{0, 1, 0, 0, 0};
  int e1_sw  [5] = '{0, 0, 0, 0, 1};
  int e2_st  [9] = '{2, 2, 2, 3, 4, 4, 4, 4, 4};

  initial begin
    int ramw_lo;
    int guard;
    int wr_addr[$];

    nclr = 1'b0; go = 1'b0; func = 3'd0; add = 4'd0; blk = 1'b0;
    #1;
    chk("rst_st", b1.St, 0);
    chk("rst_busy", b1.BUSY, 0);
    chk("rst_nramw", b3.n_RAMW, 1);
    chk("rst_led", b3.LEDLTCH, 0);
    chk("rst_sel", b1.ADDR_SEL, 0);
    chk("rst_src_func0", {b1.n_ROMO, b1.n_RAMO, b1.n_SWBEN}, 3'b011);
    cyc(); cyc();
    nclr = 1'b1;

    tbl[0]  = '{3'd0, 1'b0, 3'b011};
    tbl[1]  = '{3'd0, 1'b1, 3'b011};
    tbl[2]  = '{3'd1, 1'b0, 3'b101};
    tbl[3]  = '{3'd1, 1'b1, 3'b101};
    tbl[4]  = '{3'd2, 1'b0, 3'b110};
    tbl[5]  = '{3'd2, 1'b1, 3'b110};
    tbl[6]  = '{3'd3, 1'b0, 3'b111};
    tbl[7]  = '{3'd4, 1'b0, 3'b111};
    tbl[8]  = '{3'd5, 1'b0, 3'b111};
    tbl[9]  = '{3'd6, 1'b0, 3'b111};
    tbl[10] = '{3'd7, 1'b0, 3'b111};
    for (int v = 0; v < 11; v++) begin
      func = tbl[v].func; go = tbl[v].go;
      cyc(); #1;
      chk("tbl_src", {b1.n_ROMO, b1.n_RAMO, b1.n_SWBEN}, tbl[v].exp_n);
      chk("tbl_st", {b1.St, b3.St}, 6'd0);
    end
    go = 1'b0; cyc();

    // SW->LED, single GO pulse, WR_CYCLES=1 instance
    func = 3'd5; go = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(); go = 1'b0; #1;
      chk("led_st", b1.St, e1_st[k]);
      chk("led_strobe", b1.LEDLTCH, e1_led[k]);
      chk("led_swben", b1.n_SWBEN, e1_sw[k]);
    end
    repeat (8) cyc();

    // ROM->RAM, WR_CYCLES=3, FUNC moved to 0 in SETUP, GO held in WAIT_REL
    func = 3'd4; go = 1'b1;
    cyc(); #1;
    chk("r2r_setup_st", b3.St, 1);
    chk("r2r_setup_romo", b3.n_ROMO, 0);
    func = 3'd0;
    ramw_lo = 0;
    for (int k = 0; k < 9; k++) begin
      cyc(); #1;
      if (b3.n_RAMW == 1'b0) ramw_lo++;
      chk("r2r_st", b3.St, e2_st[k]);
      chk("r2r_nramw", b3.n_RAMW, (e2_st[k] == 2) ? 0 : 1);
      chk("r2r_romo", b3.n_ROMO, 0);
    end
    chk("r2r_wr_len", ramw_lo, 3);
    go = 1'b0;
    cyc(); #1;
    chk("r2r_release_st", b3.St, 0);
    chk("r2r_release_busy", b3.BUSY, 0);
    repeat (4) cyc();

    // asynchronous reset while the WR_CYCLES=3 instance is writing
    func = 3'd3; go = 1'b1;
    cyc(); go = 1'b0;
    cyc(); #1;
    chk("rstw_pre_st", b3.St, 2);
    chk("rstw_pre_nramw", b3.n_RAMW, 0);
    nclr = 1'b0;
    #1;
    chk("rstw_nramw", b3.n_RAMW, 1);
    chk("rstw_led", b3.LEDLTCH, 0);
    chk("rstw_st", b3.St, 0);
    chk("rstw_busy", b3.BUSY, 0);
    cyc(); nclr = 1'b1;
    cyc();

`ifdef PLAYBUS_BLOCK_COPY_EN
    func = 3'd3; blk = 1'b1; add = 4'd13; go = 1'b1;
    cyc(); go = 1'b0; blk = 1'b0;
    guard = 0;
    while (b1.St != 3'd0 && guard < 60) begin
      #1;
      if (b1.n_RAMW == 1'b0) wr_addr.push_back(int'(b1.ADDR_OUT));
      if (b1.St == 3'd5) chk("blk_src_off", {b1.n_ROMO, b1.n_RAMO, b1.n_SWBEN}, 3'b111);
      cyc(); guard++;
    end
    chk("blk_timeout", guard < 60, 1);
    chk("blk_nwrites", wr_addr.size(), 3);
    for (int k = 0; k < 3; k++)
      chk("blk_addr", (k < wr_addr.size()) ? wr_addr[k] : -1, 13 + k);
    #1;
    chk("blk_sel_after", b1.ADDR_SEL, 0);
    repeat (30) cyc();
`endif

    nclr = 1'b0; go = 1'b0; blk = 1'b0; add = 4'd0;
    model_reset();
    cyc(); nclr = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge ck);
      nclr = ($urandom_range(149) != 0);
      go   = ($urandom_range(99) < 40);
      func = 3'($urandom_range(7));
      add  = 4'($urandom_range(15));
      blk  = 1'($urandom_range(1));
      if (!nclr) model_reset();
      #1;
      chk("rand_u1", obs1, model_out(0));
      chk("rand_u3", obs3, model_out(1));
      @(posedge ck);
      if (nclr) begin
        model_step(0, 1);
        model_step(1, 3);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
